uart_tx_framed: RTL



---
 rtl/uart_tx_framed.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/uart_tx_framed.sv
// UART transmitter. Accepts one word per valid/ready handshake and sends it as
// one frame: start bit, data LSB first, optional parity bit, 1 or 2 stop bits.
// Every serial bit lasts CLKS_PER_BIT clocks. tx_out, tx_busy and tx_done are
// registered. Each one is loaded on the same edge that moves the FSM into its
// new state, so the line always reflects the state the FSM has just entered.
//
// Handshake: a word transfers on a posedge where tx_valid && tx_ready.
// tx_ready is high only in IDLE. The upstream holds tx_valid and tx_data
// until it sees tx_ready. tx_valid is ignored while a frame is in flight.
// The word is copied at the handshake, so later tx_data changes are harmless.
module uart_tx_framed #(
  parameter int CLKS_PER_BIT = 1,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx_out,
  output logic                 tx_busy,
  output logic                 tx_done
);

  localparam int               DIV_W     = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLKS_PER_BIT - 1);
  localparam logic [3:0]       DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]       STOP_LAST = 4'(STOP_BITS - 1);
  localparam logic             ODD_PAR   = (PARITY == 2);
  localparam logic             HAS_PAR   = (PARITY != 0);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_e;

  state_e               state_q;
  logic [DIV_W-1:0]     div_q;
  logic [3:0]           bit_q;
  logic [DATA_BITS-1:0] shift_q;
  logic                 parity_q;
  logic                 tx_out_q;
  logic                 tx_busy_q;
  logic                 tx_done_q;

  logic                 div_last_d;
  logic                 parity_d;

  // Terminal count of the per-bit divider, and the parity bit of the word being offered.
  always_comb begin
    div_last_d = (div_q == DIV_LAST);
    parity_d   = (^tx_data) ^ ODD_PAR;
  end

  // Frame sequencer. The divider restarts at 0 on every state change.
  // bit_q counts data bits in DATA and stop bits in STOP.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      div_q     <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      parity_q  <= 1'b0;
      tx_out_q  <= 1'b1;
      tx_busy_q <= 1'b0;
      tx_done_q <= 1'b0;
    end else begin
      tx_done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          tx_out_q  <= 1'b1;
          tx_busy_q <= 1'b0;
          div_q     <= '0;
          bit_q     <= '0;
          if (tx_valid) begin
            shift_q   <= tx_data;
            parity_q  <= parity_d;
            state_q   <= S_START;
            tx_out_q  <= 1'b0;
            tx_busy_q <= 1'b1;
          end
        end
        S_START: begin
          if (div_last_d) begin
            div_q    <= '0;
            state_q  <= S_DATA;
            tx_out_q <= shift_q[0];
          end else begin
            div_q <= div_q + DIV_W'(1);
          end
        end
        S_DATA: begin
          if (div_last_d) begin
            div_q   <= '0;
            shift_q <= shift_q >> 1;
            if (bit_q == DATA_LAST) begin
              bit_q <= '0;
              if (HAS_PAR) begin
                state_q  <= S_PARITY;
                tx_out_q <= parity_q;
              end else begin
                state_q  <= S_STOP;
                tx_out_q <= 1'b1;
              end
            end else begin
              bit_q    <= bit_q + 4'd1;
              tx_out_q <= shift_q[1];
            end
          end else begin
            div_q <= div_q + DIV_W'(1);
          end
        end
        S_PARITY: begin
          if (div_last_d) begin
            div_q    <= '0;
            state_q  <= S_STOP;
            tx_out_q <= 1'b1;
          end else begin
            div_q <= div_q + DIV_W'(1);
          end
        end
        S_STOP: begin
          tx_out_q <= 1'b1;
          if (div_last_d) begin
            div_q <= '0;
            if (bit_q == STOP_LAST) begin
              bit_q     <= '0;
              state_q   <= S_IDLE;
              tx_busy_q <= 1'b0;
              tx_done_q <= 1'b1;
            end else begin
              bit_q <= bit_q + 4'd1;
            end
          end else begin
            div_q <= div_q + DIV_W'(1);
          end
        end
        default: begin
          state_q   <= S_IDLE;
          div_q     <= '0;
          bit_q     <= '0;
          tx_out_q  <= 1'b1;
          tx_busy_q <= 1'b0;
        end
      endcase
    end
  end

  // Outputs: ready follows the state directly, the rest come from registers.
  always_comb begin
    tx_ready = (state_q == S_IDLE);
    tx_out   = tx_out_q;
    tx_busy  = tx_busy_q;
    tx_done  = tx_done_q;
  end

endmodule
